line_gatherer: RTL and testbench

- Upstream stage of the 640-wide line divider.
- Accepts a serial stream of per-pixel numerator/denominator pairs, one pair per beat, and assembles one full image line into parallel Numerator/Denominator arrays.
- Presents the complete line to the divider with a valid/ready handshake, holding the arrays stable until the line is consumed.
- Checks line framing and counts zero denominators so downstream logic can mask the divider's undefined results.

---
 rtl/vision_pkg.sv | 31 +++
 rtl/line_frame_checker.sv | 62 ++++++
 rtl/line_gatherer.sv | 151 +++++++++++++++
 tb/tb_line_gatherer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vision_pkg.sv
// -----------------------------------------------------------------------------
// vision_pkg
// Shared types and constants for the line gatherer / line divider pipeline.
//
// Contents:
//   PIX_W          - width of one numerator/denominator element
//   LINE_LEN       - number of elements in one image line
//   pix_t          - one element
//   line_t         - one full line of elements (also used by divider ports)
//   gather_state_t - gatherer FSM states (FILL, HOLD)
//   idx_width()    - index width for a given line length, never below 1 bit
// -----------------------------------------------------------------------------
package vision_pkg;

  localparam int PIX_W    = 24;
  localparam int LINE_LEN = 640;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [LINE_LEN-1:0] line_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } gather_state_t;

  // A line of one element still needs a 1-bit index vector to stay legal.
  function automatic int idx_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/line_frame_checker.sv
// -----------------------------------------------------------------------------
// line_frame_checker
// Combinational framing rules for the line gatherer. Given the current write
// index and the sop/eop flags of a beat, decides where the beat is written,
// what the index becomes afterwards, and whether the beat closes a line or
// breaks framing.
//
// Ports:
//   beat      in   beat is being accepted this cycle
//   sop       in   beat is first pixel of a line
//   eop       in   beat is last pixel of a line
//   wr_idx    in   current write index held by the gatherer
//   wr_pos    out  element index this beat is written to
//   next_idx  out  write index after this beat
//   err_short out  line ended or restarted before LINE_LEN beats
//   err_long  out  final element reached without eop
//   line_done out  this beat completes a line
// -----------------------------------------------------------------------------
module line_frame_checker #(
  parameter int LINE_LEN = 640,
  parameter int IDX_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1
) (
  input  logic             beat,
  input  logic             sop,
  input  logic             eop,
  input  logic [IDX_W-1:0] wr_idx,
  output logic [IDX_W-1:0] wr_pos,
  output logic [IDX_W-1:0] next_idx,
  output logic             err_short,
  output logic             err_long,
  output logic             line_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

  // sop always restarts the line at element 0, whatever the index says.
  // Reaching the last element closes the line even without eop, so a
  // missing eop cannot let the index run off the end of the array.
  always_comb begin
    wr_pos    = sop ? '0 : wr_idx;
    next_idx  = wr_idx;
    err_short = 1'b0;
    err_long  = 1'b0;
    line_done = 1'b0;
    if (beat) begin
      if (sop && (wr_idx != '0)) begin
        err_short = 1'b1;
      end
      if (wr_pos == LAST_IDX) begin
        line_done = 1'b1;
        err_long  = !eop;
        next_idx  = '0;
      end else if (eop) begin
        err_short = 1'b1;
        next_idx  = '0;
      end else begin
        next_idx = wr_pos + 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_gatherer.sv
// -----------------------------------------------------------------------------
// line_gatherer
// Upstream stage of the line divider. Collects a serial stream of
// numerator/denominator pairs into full-line parallel arrays, then presents
// the line with a valid/ready handshake and holds it stable until consumed.
// Framing is checked on the way in and zero denominators are counted so the
// consumer can mask the divider's undefined results.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous reset, active low
//   in_valid     in   input beat valid
//   in_ready     out  gatherer can accept a beat
//   in_sop       in   beat is first pixel of a line
//   in_eop       in   beat is last pixel of a line
//   in_num       in   numerator for the current pixel
//   in_den       in   denominator for the current pixel
//   Numerator    out  assembled numerators
//   Denominator  out  assembled denominators
//   line_valid   out  arrays hold a complete line
//   line_ready   in   consumer takes the line
//   zero_den_cnt out  zero denominators in the presented line
//   err_short    out  one-cycle pulse, line too short / restarted
//   err_long     out  one-cycle pulse, last element arrived without eop
//   line_cnt     out  lines presented since reset, wrapping
// -----------------------------------------------------------------------------
module line_gatherer #(
  parameter int PIX_W    = vision_pkg::PIX_W,
  parameter int LINE_LEN = vision_pkg::LINE_LEN,
  parameter int IDX_W    = vision_pkg::idx_width(LINE_LEN)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_sop,
  input  logic                           in_eop,
  input  logic [PIX_W-1:0]               in_num,
  input  logic [PIX_W-1:0]               in_den,
  output logic [LINE_LEN-1:0][PIX_W-1:0] Numerator,
  output logic [LINE_LEN-1:0][PIX_W-1:0] Denominator,
  output logic                           line_valid,
  input  logic                           line_ready,
  output logic [IDX_W:0]                 zero_den_cnt,
  output logic                           err_short,
  output logic                           err_long,
  output logic [15:0]                    line_cnt
);

  import vision_pkg::*;

  gather_state_t    state;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] wr_pos;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W:0]   zero_run;
  logic [IDX_W:0]   zero_next;
  logic             beat;
  logic             handshake;
  logic             chk_short;
  logic             chk_long;
  logic             line_done;

  // in_ready is only ever high in FILL, so a beat can never touch a held line.
  assign beat      = in_valid && in_ready;
  assign handshake = line_valid && line_ready;

  line_frame_checker #(
    .LINE_LEN (LINE_LEN),
    .IDX_W    (IDX_W)
  ) u_frame (
    .beat      (beat),
    .sop       (in_sop),
    .eop       (in_eop),
    .wr_idx    (wr_idx),
    .wr_pos    (wr_pos),
    .next_idx  (next_idx),
    .err_short (chk_short),
    .err_long  (chk_long),
    .line_done (line_done)
  );

  // Running zero count restarts whenever a beat lands on element 0, which
  // covers normal starts, resyncs and the beat after a short line.
  always_comb begin
    zero_next = (wr_pos == '0) ? '0 : zero_run;
    if (in_den == '0) begin
      zero_next = zero_next + 1'b1;
    end
  end

  // Gatherer FSM. in_ready and line_valid are registered decodes of the
  // next state so the handshake outputs are glitch free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FILL;
      wr_idx       <= '0;
      zero_run     <= '0;
      zero_den_cnt <= '0;
      line_cnt     <= '0;
      line_valid   <= 1'b0;
      in_ready     <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
    end else begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (beat) begin
            wr_idx    <= next_idx;
            zero_run  <= zero_next;
            err_short <= chk_short;
            err_long  <= chk_long;
            if (line_done) begin
              state        <= HOLD;
              line_valid   <= 1'b1;
              in_ready     <= 1'b0;
              zero_den_cnt <= zero_next;
              line_cnt     <= line_cnt + 16'd1;
            end
          end
        end
        HOLD: begin
          if (handshake) begin
            state      <= FILL;
            line_valid <= 1'b0;
            in_ready   <= 1'b1;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

  // Line storage. Discarded partial lines leave their data in place; only
  // a presented line is meaningful to the consumer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Numerator   <= '0;
      Denominator <= '0;
    end else if (beat) begin
      Numerator[wr_pos]   <= in_num;
      Denominator[wr_pos] <= in_den;
    end
  end

endmodule

// File: tb/tb_line_gatherer.sv
// -----------------------------------------------------------------------------
// tb_line_gatherer
// Self-checking bench for line_gatherer: a table of line scenarios with
// hand-computed results, plus hand-written backpressure and async reset
// sequences.
// -----------------------------------------------------------------------------
module tb_line_gatherer;

  localparam int PW = 24;
  localparam int LL = 640;
  localparam int IW = 10;

  logic                     clk;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sop;
  logic                     in_eop;
  logic [PW-1:0]            in_num;
  logic [PW-1:0]            in_den;
  logic [LL-1:0][PW-1:0]    Numerator;
  logic [LL-1:0][PW-1:0]    Denominator;
  logic                     line_valid;
  logic                     line_ready;
  logic [IW:0]              zero_den_cnt;
  logic                     err_short;
  logic                     err_long;
  logic [15:0]              line_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string label;
    int    len;
    int    eop_at;
    int    sop2_at;
    int    zero_a;
    int    zero_b;
    int    zero_c;
    int    base;
    bit    exp_valid;
    int    exp_short;
    int    exp_long;
    int    exp_zero;
    int    exp_cnt;
    int    idx_num;
    int    exp_num;
    int    idx_den;
    int    exp_den;
  } vec_t;

  vec_t vecs[8];

  line_gatherer #(
    .PIX_W    (PW),
    .LINE_LEN (LL),
    .IDX_W    (IW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .in_num       (in_num),
    .in_den       (in_den),
    .Numerator    (Numerator),
    .Denominator  (Denominator),
    .line_valid   (line_valid),
    .line_ready   (line_ready),
    .zero_den_cnt (zero_den_cnt),
    .err_short    (err_short),
    .err_long     (err_long),
    .line_cnt     (line_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [PW-1:0] denFor(input vec_t v, input int b);
    if (b == v.zero_a || b == v.zero_b || b == v.zero_c) return '0;
    return PW'(v.base + b + 1);
  endfunction

  task automatic waitReady();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: in_ready got %0b, expected 1", in_ready);
    end
  endtask

  // Sends one scenario's beats, counting error pulses seen after each edge.
  task automatic applyStimulus(input vec_t v, output int n_short, output int n_long);
    n_short = 0;
    n_long  = 0;
    for (int b = 0; b < v.len; b++) begin
      waitReady();
      in_valid = 1'b1;
      in_sop   = (b == 0) || (b == v.sop2_at);
      in_eop   = (b == v.eop_at);
      in_num   = PW'(v.base + b);
      in_den   = denFor(v, b);
      @(posedge clk); #1;
      if (err_short === 1'b1) n_short++;
      if (err_long === 1'b1) n_long++;
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic checkLine(input vec_t v, input int n_short, input int n_long);
    checkOutput({v.label, "_line_valid"}, 32'(line_valid), 32'(v.exp_valid));
    checkOutput({v.label, "_in_ready"}, 32'(in_ready), 32'(!v.exp_valid));
    checkOutput({v.label, "_err_short"}, n_short, v.exp_short);
    checkOutput({v.label, "_err_long"}, n_long, v.exp_long);
    checkOutput({v.label, "_zero_den_cnt"}, 32'(zero_den_cnt), v.exp_zero);
    checkOutput({v.label, "_line_cnt"}, 32'(line_cnt), v.exp_cnt);
    checkOutput({v.label, "_num"}, 32'(Numerator[v.idx_num]), v.exp_num);
    checkOutput({v.label, "_den"}, 32'(Denominator[v.idx_den]), v.exp_den);
  endtask

  task automatic takeLine(input string label);
    line_ready = 1'b1;
    @(posedge clk); #1;
    line_ready = 1'b0;
    checkOutput({label, "_take_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({label, "_take_line_valid"}, 32'(line_valid), 32'd0);
  endtask

  initial begin
    int ns;
    int nl;
    int bad;

    // label, len, eop, sop2, zeros(a,b,c), base, valid, short, long, zero, cnt,
    // num idx, num, den idx, den
    vecs[0] = '{"normal",  640, 639,  -1, -1, -1,  -1,    0, 1'b1, 0, 0, 0, 1,  5,    5, 639,  640};
    vecs[1] = '{"short",   100,  99,  -1, -1, -1,  -1, 1000, 1'b0, 1, 0, 0, 1,  0, 1000,  99, 1100};
    vecs[2] = '{"after",   640, 639,  -1, -1, -1,  -1, 2000, 1'b1, 0, 0, 0, 2,  0, 2000, 639, 2640};
    vecs[3] = '{"resync",  940, 939, 300, -1, -1,  -1, 3000, 1'b1, 1, 0, 0, 3,  0, 3300, 639, 3940};
    vecs[4] = '{"zerolong",640,  -1,  -1,  0, 10, 639, 4000, 1'b1, 0, 1, 3, 4, 10, 4010,  10,    0};
    vecs[5] = '{"bp",      640, 639,  -1, -1, -1,  -1, 5000, 1'b1, 0, 0, 0, 5,  7, 5007, 639, 5640};
    vecs[6] = '{"second",  640, 639,  -1, -1, -1,  -1, 6000, 1'b1, 0, 0, 0, 6,  0, 6000, 639, 6640};
    vecs[7] = '{"rst",     640, 639,  -1,  0, -1,  -1, 7000, 1'b1, 0, 0, 1, 7,  1, 7001,   0,    0};

    reset      = 1'b0;
    in_valid   = 1'b0;
    in_sop     = 1'b0;
    in_eop     = 1'b0;
    in_num     = '0;
    in_den     = '0;
    line_ready = 1'b0;

    @(posedge clk); #1;
    checkOutput("reset_line_valid", 32'(line_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_line_cnt", 32'(line_cnt), 32'd0);
    checkOutput("reset_zero_den_cnt", 32'(zero_den_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);

    // Table-driven line scenarios.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], ns, nl);
      checkLine(vecs[i], ns, nl);
      if (vecs[i].exp_valid) takeLine(vecs[i].label);
    end

    // Backpressure: line held for 50 cycles while upstream keeps pushing.
    applyStimulus(vecs[5], ns, nl);
    checkLine(vecs[5], ns, nl);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      in_valid = 1'b1;
      in_sop   = 1'b1;
      in_num   = PW'(999);
      in_den   = '0;
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || line_valid !== 1'b1 || Numerator[0] !== PW'(5000) ||
          Numerator[7] !== PW'(5007) || Denominator[639] !== PW'(5640) ||
          zero_den_cnt !== '0 || line_cnt !== 16'd5) bad++;
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    checkOutput("bp_unstable_cycles", bad, 0);
    takeLine("bp");
    applyStimulus(vecs[6], ns, nl);
    checkLine(vecs[6], ns, nl);
    takeLine("second");

    // Async reset while a line is held.
    applyStimulus(vecs[7], ns, nl);
    checkLine(vecs[7], ns, nl);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_line_valid", 32'(line_valid), 32'd0);
    checkOutput("async_line_cnt", 32'(line_cnt), 32'd0);
    checkOutput("async_zero_den_cnt", 32'(zero_den_cnt), 32'd0);
    checkOutput("async_in_ready", 32'(in_ready), 32'd0);
    checkOutput("async_num1", 32'(Numerator[1]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("async_release_in_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
